fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decode/control stage in the reduced RISC-V core.
- Holds the PC, issues one read at a time to instruction memory over a request/response handshake, and buffers the returned word.
- Presents the word with a valid flag to decode, then advances the PC to PC+4 or PC+ImmOp as directed by the decode stage's PCsrc.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address.
- DATA_WIDTH, 32, instruction word width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- PCsrc  input  1  branch-taken flag from decode; sampled only on the consume cycle.
- ImmOp  input  ADDR_WIDTH  sign-extended branch offset from decode; sampled only on the consume cycle.
- imem_req_o  output  1  read request to instruction memory.
- imem_addr_o  output  ADDR_WIDTH  read address; always equals pc_o.
- imem_ready_i  input  1  memory accepts request this cycle.
- imem_rvalid_i  input  1  read data valid.
- imem_rdata_i  input  DATA_WIDTH  read data.
- instr_o  output  DATA_WIDTH  buffered instruction to decode.
- instr_valid_o  output  1  instr_o holds an unconsumed instruction.
- instr_ready_i  input  1  decode consumes instr_o this cycle.
- pc_o  output  ADDR_WIDTH  address of the current or outstanding fetch.

Behaviour:
- Reset (async, rst=1):
  - pc_o=RESET_PC, instr_o=0, instr_valid_o=0, state=REQ.
  - imem_req_o is forced 0 while rst=1.
  - Reset at any point aborts an outstanding request; its response is never captured.
- FSM states: REQ, WAIT, HOLD.
- REQ:
  - imem_req_o=1, imem_addr_o=pc_o.
  - If imem_ready_i=1, go to WAIT next cycle; otherwise stay in REQ with address held stable.
- WAIT:
  - imem_req_o=0.
  - On imem_rvalid_i=1: instr_o<=imem_rdata_i, instr_valid_o<=1, go to HOLD.
  - Response may arrive in the first WAIT cycle or any later one; there is no timeout.
- HOLD:
  - instr_o and pc_o are held stable; imem_req_o=0.
  - On instr_ready_i=1 (consume cycle):
    - instr_valid_o<=0.
    - pc_o<=pc_o+ImmOp if PCsrc=1, else pc_o+4.
    - Go to REQ.
  - instr_ready_i=0 stalls indefinitely with no state change.
- imem_rvalid_i outside WAIT is ignored; instr_o is not modified.
- instr_ready_i outside HOLD is ignored; PC does not change.
- Exactly one outstanding memory request at any time.
- PC arithmetic:
  - Modulo 2^ADDR_WIDTH two's-complement; overflow bits are discarded.
  - 32'hFFFF_FFFC+4 = 32'h0000_0000.
  - Negative ImmOp produces a backward branch.
- No alignment checking: the low PC bits pass through unchanged.
- Fetch throughput: minimum 3 cycles per instruction (REQ, WAIT, HOLD) with zero-wait memory and immediate consume.
- imem_req_o and imem_addr_o are combinational from state and PC; instr_o, instr_valid_o and pc_o are registered.

Test Plan:
- Reset, then release with imem_ready_i=1 and 1-cycle rvalid:
  - -> imem_addr_o=0x0 in REQ.
  - -> instr_valid_o=1, instr_o=rdata 2 cycles after REQ.
  - -> after consume with PCsrc=0, next imem_addr_o=0x4.
- Memory back-pressure: imem_ready_i low 3 cycles, rvalid delayed 4 cycles -> imem_req_o held 1 with stable address; instr_valid_o rises only with rvalid.
- Taken branch: instr at pc 0x10 consumed with PCsrc=1, ImmOp=32'hFFFF_FFF8 -> next imem_addr_o=0x08; with PCsrc=0 -> 0x14.
- Decode stall: instr_ready_i low 5 cycles in HOLD -> instr_o, pc_o, instr_valid_o unchanged; no new request; spurious imem_rvalid_i pulse ignored.
- Wrap-around: RESET_PC=32'hFFFF_FFFC, consume with PCsrc=0 -> next address 0x0.
- Reset asserted mid-WAIT, then rvalid pulses after release while in REQ -> pc_o=RESET_PC, instr_valid_o stays 0, stale data not captured.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage signal bundle: instruction-memory request/response and decode handoff.
// master = fetch unit side, slave = memory/decode environment side.
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  PCsrc;
  logic [ADDR_WIDTH-1:0] ImmOp;
  logic                  imem_req_o;
  logic [ADDR_WIDTH-1:0] imem_addr_o;
  logic                  imem_ready_i;
  logic                  imem_rvalid_i;
  logic [DATA_WIDTH-1:0] imem_rdata_i;
  logic [DATA_WIDTH-1:0] instr_o;
  logic                  instr_valid_o;
  logic                  instr_ready_i;
  logic [ADDR_WIDTH-1:0] pc_o;

  modport master (
    input  PCsrc, ImmOp, imem_ready_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
    output imem_req_o, imem_addr_o, instr_o, instr_valid_o, pc_o
  );

  modport slave (
    output PCsrc, ImmOp, imem_ready_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
    input  imem_req_o, imem_addr_o, instr_o, instr_valid_o, pc_o
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem read, buffers the word for decode,
// then advances the PC by 4 or by the decode-supplied branch offset.
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus,
  output logic [1:0]    dbg_state
);

  // Handshakes: an imem request transfers on a cycle with imem_req_o && imem_ready_i;
  // a response transfers on imem_rvalid_i while waiting; decode consumes on
  // instr_valid_o && instr_ready_i. Handshake inputs outside their state are ignored.

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  valid_q, valid_d;
  logic                  req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    req     = 1'b0;
    unique case (state_q)
      S_REQ: begin
        req = 1'b1;
        if (bus.imem_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_rvalid_i) begin
          instr_d = bus.imem_rdata_i;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.instr_ready_i) begin
          valid_d = 1'b0;
          // Modulo-2^ADDR_WIDTH add; carry out is intentionally dropped.
          pc_d    = pc_q + (bus.PCsrc ? bus.ImmOp : PC_STEP);
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // Request is gated by rst directly so it drops the instant reset asserts.
  assign bus.imem_req_o    = req & ~rst;
  assign bus.imem_addr_o   = pc_q;
  assign bus.pc_o          = pc_q;
  assign bus.instr_o       = instr_q;
  assign bus.instr_valid_o = valid_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, back-pressure, branches, stall, wrap and mid-fetch reset.
module tb_fetch_unit;

  logic clk;
  logic rst;
  logic rst_w;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state_w;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus  ();
  fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) busw ();

  fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk       (clk),
    .rst       (rst_w),
    .bus       (busw),
    .dbg_state (dbg_state_w)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks; each starts and ends 1 time unit after a rising edge
  task automatic fetch_ok(input logic [31:0] addr, input logic [31:0] data);
    check("req_in_req", 32'(bus.imem_req_o), 32'd1);
    check("req_addr", bus.imem_addr_o, addr);
    bus.imem_ready_i = 1'b1;
    step();
    bus.imem_ready_i = 1'b0;
    check("wait_no_req", 32'(bus.imem_req_o), 32'd0);
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = data;
    step();
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = $urandom_range(0, 32'hFFFF);
    check("valid_up", 32'(bus.instr_valid_o), 32'd1);
    exp_q.push_back(data);
  endtask

  task automatic consume(input logic src, input logic [31:0] imm, input logic [31:0] next);
    if (exp_q.size() == 0) begin
      bad++;
      total++;
      $display("FAIL sb_underflow got=empty exp=entry");
    end else begin
      check("sb_instr", bus.instr_o, exp_q.pop_front());
    end
    bus.instr_ready_i = 1'b1;
    bus.PCsrc         = src;
    bus.ImmOp         = imm;
    step();
    bus.instr_ready_i = 1'b0;
    bus.PCsrc         = 1'b0;
    bus.ImmOp         = '0;
    check("valid_clr", 32'(bus.instr_valid_o), 32'd0);
    check("next_addr", bus.imem_addr_o, next);
    check("next_req", 32'(bus.imem_req_o), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    rst_w = 1'b1;
    bus.PCsrc = 1'b0;  bus.ImmOp = '0;  bus.imem_ready_i = 1'b0;
    bus.imem_rvalid_i = 1'b0;  bus.imem_rdata_i = '0;  bus.instr_ready_i = 1'b0;
    busw.PCsrc = 1'b0; busw.ImmOp = '0; busw.imem_ready_i = 1'b0;
    busw.imem_rvalid_i = 1'b0; busw.imem_rdata_i = '0; busw.instr_ready_i = 1'b0;
    step();
    step();

    // reset state
    check("rst_pc", bus.pc_o, 32'h0);
    check("rst_instr", bus.instr_o, 32'h0);
    check("rst_valid", 32'(bus.instr_valid_o), 32'd0);
    check("rst_req", 32'(bus.imem_req_o), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    rst = 1'b0;
    #1;
    fetch_ok(32'h0, 32'h0010_0093);
    check("hold_state", 32'(dbg_state), 32'd2);
    consume(1'b0, 32'h0, 32'h4);

    // memory back-pressure; decode consume attempts in REQ must be ignored
    bus.instr_ready_i = 1'b1;
    bus.PCsrc = 1'b1;
    bus.ImmOp = 32'h100;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_req", 32'(bus.imem_req_o), 32'd1);
      check("bp_addr", bus.imem_addr_o, 32'h4);
    end
    bus.instr_ready_i = 1'b0;
    bus.PCsrc = 1'b0;
    bus.ImmOp = '0;
    bus.imem_ready_i = 1'b1;
    step();
    bus.imem_ready_i = 1'b0;
    check("bp_wait_state", 32'(dbg_state), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_wait_valid", 32'(bus.instr_valid_o), 32'd0);
      check("bp_wait_req", 32'(bus.imem_req_o), 32'd0);
    end
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'h00A0_0113;
    step();
    bus.imem_rvalid_i = 1'b0;
    check("bp_valid", 32'(bus.instr_valid_o), 32'd1);
    exp_q.push_back(32'h00A0_0113);
    consume(1'b1, 32'h8, 32'hC);
    fetch_ok(32'hC, 32'h0000_0013);
    consume(1'b0, 32'h0, 32'h10);

    // decode stall with a spurious response pulse
    fetch_ok(32'h10, 32'hFE00_0EE3);
    for (int i = 0; i < 5; i++) begin
      bus.imem_rvalid_i = (i == 2);
      bus.imem_rdata_i  = 32'hDEAD_BEEF;
      step();
      check("stall_instr", bus.instr_o, 32'hFE00_0EE3);
      check("stall_pc", bus.pc_o, 32'h10);
      check("stall_valid", 32'(bus.instr_valid_o), 32'd1);
      check("stall_req", 32'(bus.imem_req_o), 32'd0);
    end
    bus.imem_rvalid_i = 1'b0;
    consume(1'b1, 32'hFFFF_FFF8, 32'h8);

    fetch_ok(32'h8, 32'h0020_8233);
    consume(1'b1, 32'h8, 32'h10);
    fetch_ok(32'h10, 32'h4000_0033);
    consume(1'b0, 32'h0, 32'h14);

    // reset in the middle of an outstanding request
    bus.imem_ready_i = 1'b1;
    step();
    bus.imem_ready_i = 1'b0;
    check("mid_wait_state", 32'(dbg_state), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_pc", bus.pc_o, 32'h0);
    check("mid_rst_req", 32'(bus.imem_req_o), 32'd0);
    step();
    rst = 1'b0;
    #1;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'hBAAD_F00D;
    step();
    step();
    bus.imem_rvalid_i = 1'b0;
    check("stale_valid", 32'(bus.instr_valid_o), 32'd0);
    check("stale_instr", bus.instr_o, 32'h0);
    check("stale_addr", bus.imem_addr_o, 32'h0);
    check("stale_req", 32'(bus.imem_req_o), 32'd1);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    // PC wrap-around on the second instance
    rst_w = 1'b0;
    #1;
    check("wrap_addr0", busw.imem_addr_o, 32'hFFFF_FFFC);
    busw.imem_ready_i = 1'b1;
    step();
    busw.imem_ready_i = 1'b0;
    busw.imem_rvalid_i = 1'b1;
    busw.imem_rdata_i  = 32'h1234_5678;
    step();
    busw.imem_rvalid_i = 1'b0;
    check("wrap_valid", 32'(busw.instr_valid_o), 32'd1);
    check("wrap_instr", busw.instr_o, 32'h1234_5678);
    busw.instr_ready_i = 1'b1;
    step();
    busw.instr_ready_i = 1'b0;
    check("wrap_addr1", busw.imem_addr_o, 32'h0);
    check("wrap_state", 32'(dbg_state_w), 32'd0);

    // report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
